// File: rtl/brisc_pkg.sv
// brisc_pkg: shared register-file widths and types for the brisc core
package brisc_pkg;
    localparam int REG_LEN         = 32;
    localparam int REG_NUM_DEFAULT = 32;
    typedef logic [4:0]         reg_addr_t;
    typedef logic [REG_LEN-1:0] reg_data_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write bits with issue handshake, flush and pending count
// Ports: clk/reset (async, active-high); wr_en/wr_addr clear busy bits on writeback;
// issue_valid/issue_addr/issue_ready mark a destination pending; issue_acc flags an accepted issue;
// flush clears all busy bits; busy is the registered scoreboard; busy_cnt its registered popcount.
module reg_scoreboard
    import brisc_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEFAULT,
    parameter int NUM_WR  = 2,
    parameter int AW      = $clog2(REG_NUM)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]  wr_addr,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_addr,
    input  logic                       flush,
    output logic                       issue_ready,
    output logic                       issue_acc,
    output logic [REG_NUM-1:0]         busy,
    output logic [AW:0]                busy_cnt
);
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [AW:0]        cnt_q, cnt_d;
    // Depends only on registered state, so writebacks never reach issue_ready combinationally.
    assign issue_ready = !busy_q[issue_addr] || issue_addr == '0;
    assign issue_acc   = issue_valid && issue_ready;
    assign busy        = busy_q;
    assign busy_cnt    = cnt_q;
    // Clears first, then the issue set, so an issue beats a same-cycle writeback; flush beats both.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++)
            if (wr_en[w]) busy_d[wr_addr[w]] = 1'b0;
        if (issue_acc) busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
        if (flush) busy_d = '0;
        cnt_d = '0;
        for (int i = 0; i < REG_NUM; i++)
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-ported register file with pending-write scoreboard, x0 hardwired to zero
// Ports: clk/reset (async, active-high); rd_addr -> rd_data/rd_busy (combinational);
// wr_en/wr_addr/wr_data writeback ports (highest index wins); issue_valid/issue_addr/issue_ready;
// flush clears pending bits; busy_cnt counts pending registers.
// Config: define REG_FILE_BYPASS_EN to forward same-cycle writebacks to the read ports.
module reg_file_sb
    import brisc_pkg::*;
#(
    parameter int XLEN    = REG_LEN,
    parameter int REG_NUM = REG_NUM_DEFAULT,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 2,
    parameter int AW      = $clog2(REG_NUM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]  rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data,
    input  logic                         issue_valid,
    input  logic [AW-1:0]                issue_addr,
    output logic                         issue_ready,
    input  logic                         flush,
    output logic [AW:0]                  busy_cnt
);
    logic [XLEN-1:0]    regs_q [REG_NUM];
    logic [XLEN-1:0]    regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic               issue_acc;
    reg_scoreboard #(.REG_NUM(REG_NUM), .NUM_WR(NUM_WR), .AW(AW)) u_sb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush),
        .issue_ready(issue_ready), .issue_acc(issue_acc), .busy(busy), .busy_cnt(busy_cnt)
    );
    // Ascending port order lets the highest-indexed port win an address conflict.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WR; w++)
            if (wr_en[w] && wr_addr[w] != '0) regs_d[wr_addr[w]] = wr_data[w];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) regs_q <= '{default: '0};
        else       regs_q <= regs_d;
    end
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r] = regs_q[rd_addr[r]];
            rd_busy[r] = busy[rd_addr[r]];
`ifdef REG_FILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++)
                if (wr_en[w] && wr_addr[w] == rd_addr[r] && rd_addr[r] != '0) begin
                    rd_data[r] = wr_data[w];
                    rd_busy[r] = issue_acc && issue_addr == rd_addr[r];
                end
`endif
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0][4:0]  rd_addr = '0;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic [1:0]       wr_en = '0;
    logic [1:0][4:0]  wr_addr = '0;
    logic [1:0][31:0] wr_data = '0;
    logic             issue_valid = 1'b0;
    logic [4:0]       issue_addr = '0;
    logic             issue_ready;
    logic             flush = 1'b0;
    logic [5:0]       busy_cnt;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_mem [32];
    bit          m_busy [32];

    reg_file_sb dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_addr(issue_addr), .issue_ready(issue_ready), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic bit m_ready();
        return !m_busy[issue_addr] || issue_addr == 0;
    endfunction

    task automatic drive(input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic iv, input logic [4:0] ia, input logic fl);
        rd_addr[0] = ra0; rd_addr[1] = ra1; wr_en = we;
        wr_addr[0] = wa0; wr_data[0] = wd0; wr_addr[1] = wa1; wr_data[1] = wd1;
        issue_valid = iv; issue_addr = ia; flush = fl;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        drive(ra0, ra1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_model();
        int cnt;
        #1;
        for (int r = 0; r < 2; r++) begin
            logic [4:0]  a;
            logic [31:0] ed;
            logic        eb;
            a  = rd_addr[r];
            ed = m_mem[a];
            eb = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w] == a && a != 0) begin
                    ed = wr_data[w];
                    eb = issue_valid && m_ready() && issue_addr == a;
                end
`endif
            check($sformatf("rd_data[%0d]@x%0d", r, a), rd_data[r], ed);
            check($sformatf("rd_busy[%0d]@x%0d", r, a), {31'b0, rd_busy[r]}, {31'b0, eb});
        end
        check("issue_ready", {31'b0, issue_ready}, {31'b0, m_ready()});
        cnt = 0;
        for (int i = 0; i < 32; i++) cnt += int'(m_busy[i]);
        check("busy_cnt", {26'b0, busy_cnt}, cnt);
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = issue_valid && m_ready();
        for (int w = 0; w < 2; w++)
            if (wr_en[w]) begin
                if (wr_addr[w] != 0) m_mem[wr_addr[w]] = wr_data[w];
                m_busy[wr_addr[w]] = 1'b0;
            end
        if (acc && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idle(5'(2*i), 5'(2*i+1));
            check_model();
            tick();
        end
        drive(5, 0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0, 1'b0);
        check_model();
`ifdef REG_FILE_BYPASS_EN
        check("x5 same cycle", rd_data[0], 32'hDEADBEEF);
`else
        check("x5 same cycle", rd_data[0], 32'h0);
`endif
        tick();
        idle(5, 0);
        check_model();
        check("x5 next cycle", rd_data[0], 32'hDEADBEEF);
        drive(7, 0, 2'b11, 7, 32'h11, 7, 32'h22, 1'b0, 0, 1'b0);
        check_model();
        tick();
        drive(7, 0, 2'b01, 0, 32'hFF, 0, 0, 1'b0, 0, 1'b0);
        check_model();
        tick();
        idle(7, 0);
        check_model();
        check("x7 conflict", rd_data[0], 32'h22);
        check("x0 write ignored", rd_data[1], 32'h0);
        drive(3, 0, 2'b00, 0, 0, 0, 0, 1'b1, 3, 1'b0);
        check_model();
        tick();
        drive(3, 0, 2'b00, 0, 0, 0, 0, 1'b1, 3, 1'b0);
        check_model();
        check("busy x3", {31'b0, rd_busy[0]}, 32'h1);
        check("ready x3", {31'b0, issue_ready}, 32'h0);
        check("cnt x3", {26'b0, busy_cnt}, 32'h1);
        tick();
        drive(3, 0, 2'b10, 0, 0, 3, 32'h33, 1'b0, 0, 1'b0);
        check_model();
        tick();
        idle(3, 0);
        check_model();
        check("x3 cleared", {31'b0, rd_busy[0]}, 32'h0);
        check("cnt cleared", {26'b0, busy_cnt}, 32'h0);
        drive(9, 0, 2'b01, 9, 32'h99, 0, 0, 1'b1, 9, 1'b0);
        check_model();
        tick();
        idle(9, 0);
        check_model();
        check("issue beats wb", {31'b0, rd_busy[0]}, 32'h1);
        drive(9, 4, 2'b00, 0, 0, 0, 0, 1'b1, 4, 1'b1);
        check_model();
        tick();
        idle(9, 4);
        check_model();
        check("flush x9", {31'b0, rd_busy[0]}, 32'h0);
        check("flush x4", {31'b0, rd_busy[1]}, 32'h0);
        check("flush cnt", {26'b0, busy_cnt}, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            drive(5, 7, 2'b00, 0, 0, 0, 0, 1'b1, 5'(i), 1'b0);
            check_model();
            tick();
        end
        idle(5, 7);
        check_model();
        check("cnt before reset", {26'b0, busy_cnt}, 32'h3);
        #2 reset = 1'b1;
        #1;
        check("reset cnt", {26'b0, busy_cnt}, 32'h0);
        check("reset x5", rd_data[0], 32'h0);
        check("reset x7", rd_data[1], 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [1:0] we;
            we[0] = $urandom_range(3, 0) == 0;
            we[1] = $urandom_range(3, 0) == 0;
            drive(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), we,
                  5'($urandom_range(31, 0)), $urandom(), 5'($urandom_range(31, 0)), $urandom(),
                  1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom_range(15, 0) == 0);
            check_model();
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
